// File: rtl/mem_stage_vl_pkg.sv
// mem_stage_vl_pkg: shared definitions for the variable-latency MEM stage.
//   - bus widths for the EX->MEM, MEM->WB and MEM->ID forwarding buses
//   - load_op one-hot bit positions ({b, h, w, bu, hu})
//   - FSM state encoding and the packed EX->MEM bus layout
package mem_stage_vl_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 77;
    localparam int unsigned MS_TO_WS_BUS_WD = 70;
    localparam int unsigned MS_FW_BUS_WD    = 39;

    localparam int unsigned LD_B  = 4;
    localparam int unsigned LD_H  = 3;
    localparam int unsigned LD_W  = 2;
    localparam int unsigned LD_BU = 1;
    localparam int unsigned LD_HU = 0;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StWait  = 2'd1,
        StReady = 2'd2
    } ms_state_e;

    // First-listed field is the MSB of es_to_ms_bus.
    typedef struct packed {
        logic [4:0]  load_op;
        logic        mem_req;
        logic [31:0] pc;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_vl_if.sv
// mem_stage_vl_if: handshake and bus signals around the MEM stage.
//   slave  modport: the MEM stage (consumes EX bus, SRAM response, flushes)
//   master modport: the surrounding pipeline / SRAM model driving the stage
// Parameter DATA_W sets the width of data_sram_rdata (32 or 64).
interface mem_stage_vl_if
    import mem_stage_vl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FW_BUS_WD-1:0]    ms_fw_bus;
    logic                       ms_flush;
    logic                       es_flush_req;
    logic                       data_sram_data_ok;
    logic [DATA_W-1:0]          data_sram_rdata;
    logic                       ms_discard_busy;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, ms_flush, es_flush_req,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fw_bus, ms_discard_busy
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, ms_flush, es_flush_req,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fw_bus, ms_discard_busy
    );

endinterface

// File: rtl/mem_stage_vl_load_align.sv
// mem_stage_vl_load_align: combinational load lane select and extension.
//   rdata   : raw response word, DATA_W bits
//   offset  : low address bits selecting the byte lane
//   load_op : one-hot {b, h, w, bu, hu}
//   result  : 32-bit aligned, sign/zero-extended load value
// Misaligned low bits are simply masked off for h/w accesses.
module mem_stage_vl_load_align
    import mem_stage_vl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]           rdata,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [4:0]                  load_op,
    output logic [31:0]                 result
);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned SH_W  = OFF_W + 3;

    logic [SH_W-1:0] sh_byte, sh_half, sh_word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     word_v;

    // Bit shift amounts; clearing low offset bits picks the containing half/word.
    assign sh_byte = {offset, 3'b000};
    assign sh_half = sh_byte & ~SH_W'(8);
    assign sh_word = sh_byte & ~SH_W'(24);

    assign byte_v = 8'(rdata >> sh_byte);
    assign half_v = 16'(rdata >> sh_half);
    assign word_v = 32'(rdata >> sh_word);

    always_comb begin
        result = word_v;
        if (load_op[LD_B]) begin
            result = {{24{byte_v[7]}}, byte_v};
        end else if (load_op[LD_BU]) begin
            result = {24'b0, byte_v};
        end else if (load_op[LD_H]) begin
            result = {{16{half_v[15]}}, half_v};
        end else if (load_op[LD_HU]) begin
            result = {16'b0, half_v};
        end
    end

endmodule

// File: rtl/mem_stage_vl.sv
// mem_stage_vl: variable-latency MEM stage between EX and WB.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mem_stage_vl_if.slave -- EX->MEM handshake/bus, MEM->WB handshake/bus,
//                forwarding bus to ID, flushes, data SRAM response, discard-busy flag
// Waits for the in-order data_ok owed to the current instruction, aligns loads, and
// drops responses owed to squashed instructions via a saturating discard counter.
// Optional feature macro MS_LOAD_FW_EN: forward load results from MEM once data arrives.
module mem_stage_vl
    import mem_stage_vl_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic           clk,
    input logic           reset,
    mem_stage_vl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned SUM_W = CNT_W + 2;

    ms_state_e         state_q;
    es_to_ms_t         bus_q;
    logic [DATA_W-1:0] rdata_buf_q;
    logic [CNT_W-1:0]  discard_cnt_q;

    es_to_ms_t         es_in;
    logic              ms_valid, in_wait, cnt_nz, deliver, ms_ready_go, ms_allowin, latch;
    logic              flush_owed, drop, fw_ready;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] live_rdata;
    logic [31:0]       load_result, final_result;
    logic              unused_mem_req;

    assign es_in          = bus.es_to_ms_bus;
    assign unused_mem_req = bus_q.mem_req;

    assign ms_valid    = state_q != StEmpty;
    assign in_wait     = state_q == StWait;
    assign cnt_nz      = |discard_cnt_q;
    // Owed responses for squashed instructions always come first, so they win.
    assign deliver     = in_wait & bus.data_sram_data_ok & ~cnt_nz;
    assign ms_ready_go = (state_q == StReady) | deliver;
    assign ms_allowin  = ~ms_valid | (bus.ws_allowin & ms_ready_go);
    assign latch       = ms_allowin & bus.es_to_ms_valid & ~bus.ms_flush;

    // Flushing a WAIT instruction whose response did not land this cycle leaves one owed.
    assign flush_owed = bus.ms_flush & in_wait & ~deliver;
    assign drop       = bus.data_sram_data_ok & cnt_nz;
    assign cnt_sum    = SUM_W'(discard_cnt_q) + SUM_W'(flush_owed) + SUM_W'(bus.es_flush_req)
                      - SUM_W'(drop);
    assign cnt_next   = (cnt_sum > SUM_W'(MAX_OUTSTANDING)) ? CNT_W'(MAX_OUTSTANDING)
                                                           : cnt_sum[CNT_W-1:0];

    // Bypass the live response in the cycle it arrives.
    assign live_rdata = deliver ? bus.data_sram_rdata : rdata_buf_q;

    mem_stage_vl_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rdata   (live_rdata),
        .offset  (bus_q.alu_result[OFF_W-1:0]),
        .load_op (bus_q.load_op),
        .result  (load_result)
    );

    assign final_result = bus_q.res_from_mem ? load_result : bus_q.alu_result;

`ifdef MS_LOAD_FW_EN
    assign fw_ready = ms_ready_go;
`else
    assign fw_ready = ~(bus_q.res_from_mem & ms_valid);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StEmpty;
            bus_q         <= '0;
            rdata_buf_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            discard_cnt_q <= cnt_next;
            if (deliver) begin
                rdata_buf_q <= bus.data_sram_rdata;
            end
            if (bus.ms_flush) begin
                state_q <= StEmpty;
            end else if (latch) begin
                state_q <= es_in.mem_req ? StWait : StReady;
                bus_q   <= es_in;
            end else if (ms_allowin) begin
                state_q <= StEmpty;
            end else if (deliver) begin
                state_q <= StReady;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (cnt_sum <= SUM_W'(MAX_OUTSTANDING))
                else $error("mem_stage_vl: discard counter overflow");
        end
    end

    assign bus.ms_allowin      = ms_allowin;
    assign bus.ms_to_ws_valid  = ms_valid & ms_ready_go & ~bus.ms_flush;
    assign bus.ms_to_ws_bus    = {bus_q.pc, bus_q.gr_we, bus_q.dest, final_result};
    assign bus.ms_fw_bus       = {ms_valid & bus_q.gr_we, fw_ready, bus_q.dest, final_result};
    assign bus.ms_discard_busy = cnt_nz;

endmodule

// File: tb/tb_mem_stage_vl.sv
// tb_mem_stage_vl: drives a DATA_W=32 and a DATA_W=64 instance with identical control
// and checks both against a transaction-level model: a queue of owed SRAM responses
// tagged live/dead plus a record of the instruction held in MEM.
module tb_mem_stage_vl;
    import mem_stage_vl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_stage_vl_if #(.DATA_W(32)) if32 ();
    mem_stage_vl_if #(.DATA_W(64)) if64 ();

    mem_stage_vl #(.DATA_W(32), .MAX_OUTSTANDING(2)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );
    mem_stage_vl #(.DATA_W(64), .MAX_OUTSTANDING(2)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (if64)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus for the current cycle.
    logic        in_valid, in_ws, in_flush, in_esf, in_ok;
    es_to_ms_t   in_rec;
    logic [63:0] in_rdata;

    // Model: owed responses in order (1 = for the MEM instruction, 0 = to be dropped).
    bit          q[$];
    bit          m_valid;
    es_to_ms_t   m_rec;
    bit          m_got;
    logic [63:0] m_data;

    // Observations captured in the most recent step.
    logic        cap_allow, cap_tov, cap_busy;
    logic [69:0] cap32, cap64;

`ifdef MS_LOAD_FW_EN
    localparam logic [38:0] RST_FW = 39'd0;
`else
    localparam logic [38:0] RST_FW = 39'h20_0000_0000;
`endif

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_load(input int width, input logic [63:0] d,
                                             input logic [31:0] addr, input logic [4:0] op);
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        off = int'(addr[2:0]) % (width / 8);
        b   = 8'(d >> (8 * off));
        h   = 16'(d >> (16 * (off / 2)));
        w   = 32'(d >> (32 * (off / 4)));
        if (op[LD_B])  return {{24{b[7]}}, b};
        if (op[LD_BU]) return {24'b0, b};
        if (op[LD_H])  return {{16{h[15]}}, h};
        if (op[LD_HU]) return {16'b0, h};
        return w;
    endfunction

    function automatic es_to_ms_t mk(input logic [4:0] op, input logic req, input logic res,
                                     input logic [31:0] addr);
        es_to_ms_t r;
        r.load_op      = op;
        r.mem_req      = req;
        r.pc           = $urandom;
        r.res_from_mem = res;
        r.gr_we        = 1'b1;
        r.dest         = 5'($urandom);
        r.alu_result   = addr;
        return r;
    endfunction

    function automatic es_to_ms_t rand_rec(input bit allow_req);
        es_to_ms_t r;
        int        kind;
        kind           = allow_req ? int'($urandom_range(0, 3)) : 0;
        r.load_op      = (kind >= 2) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
        r.mem_req      = kind != 0;
        r.pc           = $urandom;
        r.res_from_mem = kind >= 2;
        r.gr_we        = 1'($urandom);
        r.dest         = 5'($urandom);
        r.alu_result   = $urandom;
        return r;
    endfunction

    function automatic int dead_count();
        int n = 0;
        foreach (q[i]) if (!q[i]) n++;
        return n;
    endfunction

    task automatic set_idle();
        in_valid = 1'b0;
        in_rec   = '0;
        in_ws    = 1'b1;
        in_flush = 1'b0;
        in_esf   = 1'b0;
        in_ok    = 1'b0;
        in_rdata = {$urandom, $urandom};
    endtask

    task automatic drive();
        if32.es_to_ms_valid    = in_valid;
        if32.es_to_ms_bus      = in_rec;
        if32.ws_allowin        = in_ws;
        if32.ms_flush          = in_flush;
        if32.es_flush_req      = in_esf;
        if32.data_sram_data_ok = in_ok;
        if32.data_sram_rdata   = in_rdata[31:0];
        if64.es_to_ms_valid    = in_valid;
        if64.es_to_ms_bus      = in_rec;
        if64.ws_allowin        = in_ws;
        if64.ms_flush          = in_flush;
        if64.es_flush_req      = in_esf;
        if64.data_sram_data_ok = in_ok;
        if64.data_sram_rdata   = in_rdata;
    endtask

    // One clock cycle: apply inputs at the negedge, check, then advance the model.
    task automatic step();
        bit          deliver, ready, allow, tov, fwr;
        logic [63:0] now_data;
        logic [31:0] r32, r64;
        drive();
        #1;
        deliver  = in_ok && (q.size() > 0) && q[0];
        ready    = m_valid && (!m_rec.mem_req || m_got || deliver);
        allow    = !m_valid || (in_ws && ready);
        tov      = ready && !in_flush;
`ifdef MS_LOAD_FW_EN
        fwr      = ready;
`else
        fwr      = !(m_valid && m_rec.res_from_mem);
`endif
        now_data = m_got ? m_data : in_rdata;
        r32 = m_rec.res_from_mem ? ref_load(32, now_data, m_rec.alu_result, m_rec.load_op)
                                 : m_rec.alu_result;
        r64 = m_rec.res_from_mem ? ref_load(64, now_data, m_rec.alu_result, m_rec.load_op)
                                 : m_rec.alu_result;
        cap_allow = if32.ms_allowin;
        cap_tov   = if32.ms_to_ws_valid;
        cap_busy  = if32.ms_discard_busy;
        cap32     = if32.ms_to_ws_bus;
        cap64     = if64.ms_to_ws_bus;
        check("allowin32", 70'(if32.ms_allowin), 70'(allow));
        check("allowin64", 70'(if64.ms_allowin), 70'(allow));
        check("to_ws_valid32", 70'(if32.ms_to_ws_valid), 70'(tov));
        check("to_ws_valid64", 70'(if64.ms_to_ws_valid), 70'(tov));
        check("busy32", 70'(if32.ms_discard_busy), 70'(dead_count() != 0));
        check("busy64", 70'(if64.ms_discard_busy), 70'(dead_count() != 0));
        check("fw_ctl32", 70'(if32.ms_fw_bus[38:37]), 70'({m_valid && m_rec.gr_we, fwr}));
        check("fw_ctl64", 70'(if64.ms_fw_bus[38:37]), 70'({m_valid && m_rec.gr_we, fwr}));
        if (tov) begin
            check("to_ws_bus32", if32.ms_to_ws_bus, {m_rec.pc, m_rec.gr_we, m_rec.dest, r32});
            check("to_ws_bus64", if64.ms_to_ws_bus, {m_rec.pc, m_rec.gr_we, m_rec.dest, r64});
        end
        if (ready) begin
            check("fw_bus32", 70'(if32.ms_fw_bus), 70'({m_rec.gr_we, fwr, m_rec.dest, r32}));
            check("fw_bus64", 70'(if64.ms_fw_bus), 70'({m_rec.gr_we, fwr, m_rec.dest, r64}));
        end
        @(posedge clk);
        if (in_ok && q.size() > 0) void'(q.pop_front());
        if (in_flush) begin
            foreach (q[i]) q[i] = 1'b0;
            m_valid = 1'b0;
        end else if (allow && in_valid) begin
            m_valid = 1'b1;
            m_rec   = in_rec;
            m_got   = 1'b0;
            if (in_rec.mem_req) q.push_back(1'b1);
        end else if (allow) begin
            m_valid = 1'b0;
        end else if (deliver) begin
            m_got  = 1'b1;
            m_data = in_rdata;
        end
        if (in_esf) q.push_back(1'b0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_allowin32"}, 70'(if32.ms_allowin), 70'(1));
        check({tag, "_allowin64"}, 70'(if64.ms_allowin), 70'(1));
        check({tag, "_tov32"}, 70'(if32.ms_to_ws_valid), 70'(0));
        check({tag, "_tov64"}, 70'(if64.ms_to_ws_valid), 70'(0));
        check({tag, "_bus32"}, if32.ms_to_ws_bus, 70'(0));
        check({tag, "_bus64"}, if64.ms_to_ws_bus, 70'(0));
        check({tag, "_fw32"}, 70'(if32.ms_fw_bus), 70'(RST_FW));
        check({tag, "_busy32"}, 70'(if32.ms_discard_busy), 70'(0));
        check({tag, "_busy64"}, 70'(if64.ms_discard_busy), 70'(0));
    endtask

    initial begin
        int dn;
        bit waiting;
        q.delete();
        m_valid = 1'b0;
        m_rec   = '0;
        m_got   = 1'b0;
        m_data  = '0;
        set_idle();
        drive();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // ALU op: result next cycle.
        set_idle(); in_valid = 1'b1; in_rec = mk(5'd0, 1'b0, 1'b0, 32'h1234); step();
        set_idle(); step();
        check("alu_valid", 70'(cap_tov), 70'(1));
        check("alu_res32", 70'(cap32[31:0]), 70'(32'h1234));
        check("alu_res64", 70'(cap64[31:0]), 70'(32'h1234));

        // ld.b at ...3, response after a 3-cycle gap.
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b10000, 1'b1, 1'b1, 32'h1003); step();
        for (int i = 0; i < 3; i++) begin
            set_idle(); step();
            check("ldb_stall", 70'(cap_allow), 70'(0));
        end
        set_idle(); in_ok = 1'b1; in_rdata = 64'h0000_0000_80FF_0000; step();
        check("ldb_valid", 70'(cap_tov), 70'(1));
        check("ldb_res32", 70'(cap32[31:0]), 70'(32'hFFFF_FF80));
        check("ldb_res64", 70'(cap64[31:0]), 70'(32'hFFFF_FF80));

        // ld.hu at 0x6 and ld.w at 0x4.
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b00001, 1'b1, 1'b1, 32'h6); step();
        set_idle(); in_ok = 1'b1; in_rdata = 64'hBEEF_0000_0000_0000; step();
        check("ldhu_res64", 70'(cap64[31:0]), 70'(32'h0000_BEEF));
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b00100, 1'b1, 1'b1, 32'h4); step();
        set_idle(); in_ok = 1'b1; in_rdata = 64'h1234_5678_9ABC_DEF0; step();
        check("ldw_res64", 70'(cap64[31:0]), 70'(32'h1234_5678));
        check("ldw_res32", 70'(cap32[31:0]), 70'(32'h9ABC_DEF0));

        // Flush in WAIT plus a squashed EX request: two responses dropped.
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b00100, 1'b1, 1'b1, 32'h0); step();
        set_idle(); in_flush = 1'b1; in_esf = 1'b1; step();
        set_idle(); in_ok = 1'b1; step();
        check("drop1_busy", 70'(cap_busy), 70'(1));
        set_idle(); in_ok = 1'b1; step();
        check("drop2_busy", 70'(cap_busy), 70'(1));
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b00100, 1'b1, 1'b1, 32'h8); step();
        check("drop_done", 70'(cap_busy), 70'(0));
        set_idle(); in_ok = 1'b1; in_rdata = 64'h0000_0000_1357_2468; step();
        check("third_valid", 70'(cap_tov), 70'(1));
        check("third_res32", 70'(cap32[31:0]), 70'(32'h1357_2468));
        check("third_res64", 70'(cap64[31:0]), 70'(32'h1357_2468));

        // WB backpressure: value held until ws_allowin rises.
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b00100, 1'b1, 1'b1, 32'h0); step();
        set_idle(); in_ws = 1'b0; in_ok = 1'b1; in_rdata = 64'h0000_0000_CAFE_F00D; step();
        for (int i = 0; i < 4; i++) begin
            set_idle(); in_ws = 1'b0; step();
            check("hold_res32", 70'(cap32[31:0]), 70'(32'hCAFE_F00D));
            check("hold_allow", 70'(cap_allow), 70'(0));
        end
        set_idle(); step();
        check("release_valid", 70'(cap_tov), 70'(1));
        check("release_res64", 70'(cap64[31:0]), 70'(32'hCAFE_F00D));
        check("release_allow", 70'(cap_allow), 70'(1));

        // Asynchronous reset while waiting with one response owed.
        set_idle(); in_esf = 1'b1; step();
        set_idle(); in_valid = 1'b1; in_rec = mk(5'b00100, 1'b1, 1'b1, 32'h0); step();
        set_idle(); drive();
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        q.delete();
        m_valid = 1'b0;
        m_rec   = '0;
        m_got   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic that respects the EX issue rules.
        for (int n = 0; n < 400; n++) begin
            dn      = dead_count();
            waiting = m_valid && m_rec.mem_req && !m_got;
            set_idle();
            in_ws    = $urandom_range(0, 9) < 7;
            in_flush = $urandom_range(0, 15) == 0;
            in_ok    = (q.size() > 0) && ($urandom_range(0, 9) < 4);
            if (dn == 0 && (!waiting || in_flush) && $urandom_range(0, 11) == 0) in_esf = 1'b1;
            if (!in_esf && $urandom_range(0, 9) < 6) begin
                in_valid = 1'b1;
                in_rec   = rand_rec(dn == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
